// File: rtl/mult_div_unit_pkg.sv
// Shared funct codes and state encoding for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  typedef logic [5:0] funct_t;

  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIN} muldiv_state_t;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide with architectural HI/LO; 33-cycle ops,
// MTHI/MTLO complete in one cycle. Operates on magnitudes, signs fixed in FIN.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  funct_t      fncode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        divz_q, divz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        is_mul, is_div, is_sgn;
  logic [32:0] msum;
  logic [63:0] mul_next, div_next, prod;
  logic [33:0] ddiff;

  assign is_mul = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
  assign is_div = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
  assign is_sgn = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);

  // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
  assign msum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {msum, acc_q[31:1]};

  // Divide: acc = {remainder, dividend/quotient bits}, shift left, restore on borrow.
  assign ddiff    = {1'b0, acc_q[63:31]} - {2'b00, opb_q};
  assign div_next = ddiff[33] ? {acc_q[62:0], 1'b0} : {ddiff[31:0], acc_q[30:0], 1'b1};

  assign prod = neg_q ? (64'd0 - acc_q) : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            acc_d   = {32'd0, mag(a, is_sgn)};
            opb_d   = mag(b, is_sgn);
            div_d   = is_div;
            neg_d   = is_sgn & (a[31] ^ b[31]);
            rneg_d  = is_sgn & a[31];
            divz_d  = (b == 32'd0);
            cnt_d   = 6'd0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else if (fncode == FUNCT_MTHI) begin
            hi_d = a;
          end else if (fncode == FUNCT_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end
      FIN: begin
        if (div_q) begin
          // Zero divisor leaves remainder = |a|; sign fix restores a itself.
          lo_d = divz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
          hi_d = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner sequences and a
// randomized run checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  funct_t      fncode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .fncode(fncode), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    funct_t      fn;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input funct_t fn, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rhi, output logic [31:0] rlo);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rhi = 32'd0; rlo = 32'd0;
    case (fn)
      FUNCT_MULTU: begin p = {32'd0, x} * {32'd0, y}; {rhi, rlo} = p; end
      FUNCT_MULT:  begin q = sx * sy; {rhi, rlo} = q; end
      FUNCT_DIVU:  if (y == 0) begin rlo = 32'hFFFF_FFFF; rhi = x; end
                   else begin rlo = x / y; rhi = x % y; end
      FUNCT_DIV:   if (y == 0) begin rlo = 32'hFFFF_FFFF; rhi = x; end
                   else begin q = sx / sy; r = sx % sy; rlo = q[31:0]; rhi = r[31:0]; end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input funct_t fn, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; fncode = fn; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_lo);
    lat = 0; busy_lo = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_lo++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string name, input funct_t fn, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, blo;
    issue(fn, x, y);
    wait_done(lat, blo);
    check({name, " latency"}, lat, 33);
    check({name, " busy held"}, blo, 0);
    check({name, " busy at done"}, {31'd0, busy}, 0);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
  endtask

  initial begin
    int lat, blo, dseen;
    logic [31:0] ehi, elo, rx, ry, old_hi, old_lo;
    funct_t rfn;

    vecs[0] = '{FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{FUNCT_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4] = '{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{FUNCT_MULTU, 32'd3,         32'd5,         32'd0,         32'd15};
    vecs[6] = '{FUNCT_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7] = '{FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8] = '{FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[9] = '{FUNCT_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; fncode = FUNCT_MFHI; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);

    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a,
                                       vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // MTHI then MTLO on back-to-back cycles
    @(negedge clk);
    start = 1'b1; fncode = FUNCT_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    fncode = FUNCT_MTLO; a = 32'h9ABC_DEF0;
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi busy", {31'd0, busy}, 0);
    check("mthi done", {31'd0, done}, 0);
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi kept", hi, 32'h1234_5678);
    check("mtlo busy", {31'd0, busy}, 0);
    check("mtlo done", {31'd0, done}, 0);

    // Unsupported funct is ignored
    start = 1'b1; fncode = FUNCT_MFHI; a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check("mfhi ignored hi", hi, 32'h1234_5678);
    check("mfhi ignored busy", {31'd0, busy}, 0);

    // MTLO while busy is dropped, not queued
    old_lo = lo; old_hi = hi;
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; fncode = FUNCT_MTLO; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("busy mtlo lo held", lo, old_lo);
    check("busy hi held", hi, old_hi);
    wait_done(lat, blo);
    check("busy ign lo", lo, 32'd14);
    check("busy ign hi", hi, 32'd2);
    // New op accepted in the done cycle
    issue(FUNCT_MULTU, 32'd6, 32'd7);
    check("done-cycle accept busy", {31'd0, busy}, 1);
    check("no queued mtlo", lo, 32'd14);
    wait_done(lat, blo);
    check("done-cycle accept lat", lat, 33);
    check("done-cycle accept lo", lo, 32'd42);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; fncode = FUNCT_MTHI; a = 32'hCAFE_0001;
    @(negedge clk);
    issue(FUNCT_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 0);
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    check("midreset done", {31'd0, done}, 0);
    dseen = 0;
    repeat (40) begin @(negedge clk); if (done) dseen++; end
    check("midreset no done", dseen, 0);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rfn = FUNCT_MULT;
        1: rfn = FUNCT_MULTU;
        2: rfn = FUNCT_DIV;
        default: rfn = FUNCT_DIVU;
      endcase
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = $urandom_range(1, 20);
        2: ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      model(rfn, rx, ry, ehi, elo);
      @(negedge clk);
      do_op($sformatf("rnd%0d f%02h a%08h b%08h", i, rfn, rx, ry), rfn, rx, ry, ehi, elo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
